// File: rtl/qdr2p_request_scheduler.sv
// Client front end for the QDR-II+ controller: issues read/write strobes and tags read data in order.
// Optional read-after-write stall enabled by defining QDR2P_SCHED_RAW_CHECK_EN.
module qdr2p_request_scheduler #(
  parameter int ADDR_BITS       = 18,
  parameter int CTRL_WIDTH      = 144,
  parameter int TAG_BITS        = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                               clk_ctl,
  input  logic                               rst,
  input  logic                               pll_lock,
  input  logic                               wr_req_valid,
  output logic                               wr_req_ready,
  input  logic [ADDR_BITS-1:0]               wr_req_addr,
  input  logic [CTRL_WIDTH-1:0]              wr_req_data,
  input  logic                               rd_req_valid,
  output logic                               rd_req_ready,
  input  logic [ADDR_BITS-1:0]               rd_req_addr,
  input  logic [TAG_BITS-1:0]                rd_req_tag,
  output logic                               rd_resp_valid,
  output logic [TAG_BITS-1:0]                rd_resp_tag,
  output logic [CTRL_WIDTH-1:0]              rd_resp_data,
  output logic                               ctl_wr_en,
  output logic [ADDR_BITS-1:0]               ctl_wr_addr,
  output logic [CTRL_WIDTH-1:0]              ctl_wr_data,
  output logic                               ctl_rd_en,
  output logic [ADDR_BITS-1:0]               ctl_rd_addr,
  input  logic                               ctl_rd_valid,
  input  logic [CTRL_WIDTH-1:0]              ctl_rd_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_unexpected,
  output logic                               err_timeout
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  // Handshake: a request transfers in a cycle where valid && ready; ready never waits on valid.
  logic                wr_fire;
  logic                rd_fire;
  logic                pop;
  logic                raw_hazard;
  logic [TAG_BITS-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [TO_W-1:0]     to_cnt;

`ifdef QDR2P_SCHED_RAW_CHECK_EN
  logic [ADDR_BITS-1:0] hist_addr [2];
  logic [1:0]           hist_vld;

  always_ff @(posedge clk_ctl) begin
    if (rst) begin
      hist_vld     <= '0;
      hist_addr[0] <= '0;
      hist_addr[1] <= '0;
    end else begin
      hist_vld     <= {hist_vld[0], wr_fire};
      hist_addr[0] <= wr_req_addr;
      hist_addr[1] <= hist_addr[0];
    end
  end

  // Write data is still in the controller pipeline for two cycles after acceptance.
  assign raw_hazard = (wr_fire     && (wr_req_addr  == rd_req_addr)) ||
                      (hist_vld[0] && (hist_addr[0] == rd_req_addr)) ||
                      (hist_vld[1] && (hist_addr[1] == rd_req_addr));
`else
  assign raw_hazard = 1'b0;
`endif

  assign wr_req_ready = pll_lock && !rst;
  assign rd_req_ready = pll_lock && !rst && (outstanding < MAX_CNT) && !raw_hazard;
  assign wr_fire      = wr_req_valid && wr_req_ready;
  assign rd_fire      = rd_req_valid && rd_req_ready;
  assign pop          = ctl_rd_valid && (outstanding != '0);

  always_ff @(posedge clk_ctl) begin
    if (rst) begin
      ctl_wr_en   <= 1'b0;
      ctl_wr_addr <= '0;
      ctl_wr_data <= '0;
      ctl_rd_en   <= 1'b0;
      ctl_rd_addr <= '0;
    end else begin
      ctl_wr_en   <= wr_fire;
      ctl_wr_data <= wr_fire ? wr_req_data : '0;
      if (wr_fire) ctl_wr_addr <= wr_req_addr;
      ctl_rd_en   <= rd_fire;
      if (rd_fire) ctl_rd_addr <= rd_req_addr;
    end
  end

  always_ff @(posedge clk_ctl) begin
    if (rd_fire) tag_mem[wr_ptr] <= rd_req_tag;
  end

  always_ff @(posedge clk_ctl) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      outstanding    <= '0;
      rd_resp_valid  <= 1'b0;
      rd_resp_tag    <= '0;
      rd_resp_data   <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (rd_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({rd_fire, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      rd_resp_valid <= pop;
      rd_resp_tag   <= pop ? tag_mem[rd_ptr] : '0;
      rd_resp_data  <= pop ? ctl_rd_data : '0;
      if (ctl_rd_valid && (outstanding == '0)) err_unexpected <= 1'b1;
    end
  end

  // Counts idle cycles only while something is owed to a client.
  always_ff @(posedge clk_ctl) begin
    if (rst) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (ctl_rd_valid || (outstanding == '0)) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TO_W'(1);
      if (to_cnt == TO_MAX - TO_W'(1)) err_timeout <= 1'b1;
    end
  end

endmodule
